// File: rtl/axi_stream_byte_packer.sv
// axi_stream_byte_packer: compacts sparse-keep AXI-Stream beats into dense MSB-first beats.
// Optional packet counter output enabled by defining AXIS_PACKER_PKT_CNT_EN.
`default_nettype none

module axi_stream_byte_packer #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
`ifdef AXIS_PACKER_PKT_CNT_EN
  ,
  output logic [15:0]             pkt_cnt
`endif
);

  localparam int              CW    = $clog2(2 * DATA_BYTE_WD + 1);
  localparam logic [CW-1:0]   C_W   = CW'(DATA_BYTE_WD);
  localparam logic [CW-1:0]   C_ONE = CW'(1);
  localparam logic [0:0]      ST_ACCUM = 1'b0;
  localparam logic [0:0]      ST_FLUSH = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic                    last_q, last_d;

  logic                    slot;
  logic                    accept;
  logic [DATA_WD-1:0]      cin;
  logic [CW-1:0]           n_in;
  logic [CW-1:0]           total;
  logic [2*DATA_WD-1:0]    comb;

  function automatic logic [DATA_BYTE_WD-1:0] lead_mask(input logic [CW-1:0] nb);
    lead_mask = '0;
    for (int k = 0; k < DATA_BYTE_WD; k++) begin
      if (int'(nb) >= DATA_BYTE_WD - k) lead_mask[k] = 1'b1;
    end
  endfunction

  assign slot     = !valid_q || ready_out;
  assign ready_in = slot && (state_q == ST_ACCUM);
  assign accept   = valid_in && ready_in;

  // Kept input bytes are packed to the top lanes so they line up with the stream order.
  always_comb begin
    cin  = '0;
    n_in = '0;
    for (int k = DATA_BYTE_WD - 1; k >= 0; k--) begin
      if (keep_in[k]) begin
        cin[(DATA_BYTE_WD - 1 - int'(n_in)) * 8 +: 8] = data_in[k * 8 +: 8];
        n_in = n_in + C_ONE;
      end
    end
  end

  assign total = cnt_q + n_in;
  assign comb  = {res_q, {DATA_WD{1'b0}}} | ({cin, {DATA_WD{1'b0}}} >> {cnt_q, 3'b000});

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (state_q == ST_FLUSH) begin
      if (slot) begin
        valid_d = 1'b1;
        data_d  = res_q;
        keep_d  = lead_mask(cnt_q);
        last_d  = 1'b1;
        res_d   = '0;
        cnt_d   = '0;
        state_d = ST_ACCUM;
      end
    end else begin
      if (slot) valid_d = 1'b0;
      if (accept) begin
        if (total > C_W) begin
          valid_d = 1'b1;
          data_d  = comb[2*DATA_WD-1:DATA_WD];
          keep_d  = '1;
          last_d  = 1'b0;
          res_d   = comb[DATA_WD-1:0];
          cnt_d   = total - C_W;
          if (last_in) state_d = ST_FLUSH;
        end else if (last_in) begin
          // An empty packet still produces a zero-keep beat to preserve framing.
          valid_d = 1'b1;
          data_d  = comb[2*DATA_WD-1:DATA_WD];
          keep_d  = lead_mask(total);
          last_d  = 1'b1;
          res_d   = '0;
          cnt_d   = '0;
        end else begin
          res_d = comb[2*DATA_WD-1:DATA_WD];
          cnt_d = total;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      res_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

`ifdef AXIS_PACKER_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (valid_q && ready_out && last_q && (pkt_cnt_q != 16'hFFFF)) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_byte_packer.sv
// tb_axi_stream_byte_packer: scoreboard bench for axi_stream_byte_packer (W=4).
`default_nettype none

module tb_axi_stream_byte_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
`ifdef AXIS_PACKER_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  int checks = 0;
  int passes = 0;
  int ro_mode = 0;
  int pkts_out = 0;

  beat_t      exp_q[$];
  logic [7:0] pend[$];

  logic        prev_stall = 1'b0;
  beat_t       prev_beat;

  axi_stream_byte_packer #(.DATA_WD(32), .DATA_BYTE_WD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .keep_in   (keep_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out),
    .ready_out (ready_out)
`ifdef AXIS_PACKER_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ro_mode)
      0:       ready_out = 1'b1;
      1:       ready_out = ($urandom_range(0, 3) != 0);
      default: ready_out = 1'b0;
    endcase
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Build one expected beat from the head of the pending byte stream.
  task automatic emit(input int nb, input logic l);
    beat_t b;
    b   = '0;
    b.l = l;
    for (int i = 0; i < nb; i++) begin
      b.d[(3 - i) * 8 +: 8] = pend.pop_front();
      b.k[3 - i] = 1'b1;
    end
    exp_q.push_back(b);
  endtask

  always @(negedge clk) begin
    beat_t act;
    beat_t e;
    act = {data_out, keep_out, last_out};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk(valid_out && (act == prev_beat), "stall_stable", {27'd0, valid_out, act}, {27'd1, prev_beat});
      end
      if (valid_out && !ready_out) begin
        chk(!ready_in, "stall_ready_in", {63'd0, ready_in}, 64'd0);
      end
      prev_stall = valid_out && !ready_out;
      prev_beat  = act;
      if (valid_out && ready_out) begin
        if (last_out) pkts_out++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", {27'd0, act}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk(act == e, "out_beat", {27'd0, act}, {27'd0, e});
        end
      end
      if (valid_in && ready_in) begin
        for (int k = 3; k >= 0; k--) if (keep_in[k]) pend.push_back(data_in[k * 8 +: 8]);
        while (pend.size() > 4) emit(4, 1'b0);
        if (last_in) emit(pend.size(), 1'b1);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int guard;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    guard    = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!ready_in && guard < 200);
    if (!ready_in) chk(1'b0, "send_timeout", {63'd0, ready_in}, 64'd1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  initial begin
    int guard;
    #2;
    chk({valid_out, data_out, keep_out, last_out} == '0, "reset_outputs",
        {26'd0, valid_out, data_out, keep_out, last_out}, 64'd0);
    chk(ready_in, "reset_ready_in", {63'd0, ready_in}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h0000AABB, 4'b0011, 1'b0);
    send(32'h11223344, 4'b1111, 1'b0);
    send(32'h55667788, 4'b1100, 1'b1);

    send(32'h00AABBCC, 4'b0111, 1'b0);
    send(32'h11223344, 4'b1111, 1'b1);
    @(negedge clk);
    chk(!ready_in, "flush_ready_low", {63'd0, ready_in}, 64'd0);
    @(negedge clk);
    chk(ready_in, "flush_ready_back", {63'd0, ready_in}, 64'd1);
    @(posedge clk);
    #1;

    send(32'hDEADBEEF, 4'b0000, 1'b1);

    ro_mode = 2;
    fork
      begin
        send(32'hC0C1C2C3, 4'b1111, 1'b0);
        send(32'hC4C5C6C7, 4'b1111, 1'b0);
        send(32'hC8C9CACB, 4'b1111, 1'b1);
      end
      begin
        repeat (9) @(posedge clk);
        ro_mode = 0;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    ro_mode = 2;
    send(32'hA1A2A3A4, 4'b1111, 1'b0);
    send(32'hB1B2B3B4, 4'b1100, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    pend.delete();
    pkts_out = 0;
    #1;
    chk({valid_out, data_out, keep_out, last_out} == '0, "async_reset",
        {26'd0, valid_out, data_out, keep_out, last_out}, 64'd0);
    ro_mode = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h01020304, 4'b1111, 1'b1);

    ro_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int nb;
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send($urandom, 4'($urandom), (b == nb - 1));
      end
    end

    ro_mode = 0;
    guard = 0;
    while ((exp_q.size() != 0 || valid_out) && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);

`ifdef AXIS_PACKER_PKT_CNT_EN
    chk(pkt_cnt == 16'(pkts_out), "pkt_cnt", {48'd0, pkt_cnt}, 64'(pkts_out));
    @(posedge clk);
    #1;
    force dut.pkt_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.pkt_cnt_q;
    send(32'h0A0B0C0D, 4'b1111, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(pkt_cnt == 16'hFFFF, "pkt_cnt_sat", {48'd0, pkt_cnt}, 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
